alu_8bit: RTL and testbench

//  Registered 8-bit ALU: 11 arithmetic/logic/shift/compare ops on unsigned operands A, B.

---
 rtl/alu_8bit.sv | 92 +++++++++
 tb/tb_alu_8bit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: arithmetic, logic, shift and compare ops on unsigned operands,
// with carry/borrow and zero flags updated one clock after operands are accepted.
module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic       out_valid,
  output logic [7:0] ALU_Out,
  output logic       Zero,
  output logic       Carryout
);

  localparam int unsigned DW = 8;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [OPW-1:0] OP_AND = 4'b0010;
  localparam logic [OPW-1:0] OP_OR  = 4'b0011;
  localparam logic [OPW-1:0] OP_XOR = 4'b0100;
  localparam logic [OPW-1:0] OP_NOT = 4'b0101;
  localparam logic [OPW-1:0] OP_SHL = 4'b0110;
  localparam logic [OPW-1:0] OP_SHR = 4'b0111;
  localparam logic [OPW-1:0] OP_EQ  = 4'b1000;
  localparam logic [OPW-1:0] OP_GT  = 4'b1001;
  localparam logic [OPW-1:0] OP_LT  = 4'b1010;

  logic [DW:0]   sum_c;
  logic [DW:0]   diff_c;
  logic [DW-1:0] res_c;
  logic          carry_c;

  // Ninth bit of the widened sum/difference gives carry and borrow directly.
  assign sum_c  = {1'b0, A} + {1'b0, B};
  assign diff_c = {1'b0, A} - {1'b0, B};

  // Next-result datapath; reserved opcodes fall through to zero.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        res_c   = sum_c[DW-1:0];
        carry_c = sum_c[DW];
      end
      OP_SUB: begin
        res_c   = diff_c[DW-1:0];
        carry_c = diff_c[DW];
      end
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_XOR: res_c = A ^ B;
      OP_NOT: res_c = ~A;
      OP_SHL: begin
        res_c   = {A[DW-2:0], 1'b0};
        carry_c = A[DW-1];
      end
      OP_SHR: begin
        res_c   = {1'b0, A[DW-1:1]};
        carry_c = A[0];
      end
      OP_EQ:  res_c = DW'(A == B);
      OP_GT:  res_c = DW'(A > B);
      OP_LT:  res_c = DW'(A < B);
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  // Result registers; Zero is computed from the same next value so it never lags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out   <= '0;
      Carryout  <= 1'b0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out  <= res_c;
        Carryout <= carry_c;
        Zero     <= (res_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit: reset, op sweep, carry/borrow, zero,
// hold, mid-stream reset and back-to-back issue.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic       out_valid;
  logic [7:0] ALU_Out;
  logic       Zero;
  logic       Carryout;

  int total;
  int bad;

  alu_8bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .out_valid(out_valid),
    .ALU_Out  (ALU_Out),
    .Zero     (Zero),
    .Carryout (Carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {out_valid, ALU_Out, Carryout, Zero}.
  function automatic logic [10:0] obs();
    return {out_valid, ALU_Out, Carryout, Zero};
  endfunction

  // Present inputs, clock once, settle just after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic v);
    A = a; B = b; ALU_Sel = op; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs() !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", obs(), {1'b0, 8'h00, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [10:0] exp_tab [11] = '{
      {1'b1, 8'h0F, 1'b0, 1'b0}, {1'b1, 8'h05, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b0, 1'b1},
      {1'b1, 8'h0F, 1'b0, 1'b0}, {1'b1, 8'h0F, 1'b0, 1'b0}, {1'b1, 8'hF5, 1'b0, 1'b0},
      {1'b1, 8'h14, 1'b0, 1'b0}, {1'b1, 8'h05, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b0, 1'b1},
      {1'b1, 8'h01, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b0, 1'b1}};
    for (int i = 0; i < 11; i++) begin
      step(8'h0A, 8'h05, 4'(i), 1'b1);
      total++;
      if (obs() !== exp_tab[i]) begin
        bad++;
        $display("FAIL sweep op=%h got=%h exp=%h", 4'(i), obs(), exp_tab[i]);
      end
    end
  endtask

  task automatic test_carry();
    logic [7:0]  a_tab [4]   = '{8'hFF, 8'h00, 8'h80, 8'h01};
    logic [7:0]  b_tab [4]   = '{8'h01, 8'h01, 8'h00, 8'h00};
    logic [3:0]  op_tab [4]  = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
    logic [10:0] exp_tab [4] = '{
      {1'b1, 8'h00, 1'b1, 1'b1}, {1'b1, 8'hFF, 1'b1, 1'b0},
      {1'b1, 8'h00, 1'b1, 1'b1}, {1'b1, 8'h00, 1'b1, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      step(a_tab[i], b_tab[i], op_tab[i], 1'b1);
      total++;
      if (obs() !== exp_tab[i]) begin
        bad++;
        $display("FAIL carry idx=%0d got=%h exp=%h", i, obs(), exp_tab[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [7:0]  a_tab [3]   = '{8'h00, 8'h3C, 8'h12};
    logic [7:0]  b_tab [3]   = '{8'h00, 8'h3C, 8'h34};
    logic [3:0]  op_tab [3]  = '{4'b0000, 4'b1000, 4'b1111};
    logic [10:0] exp_tab [3] = '{
      {1'b1, 8'h00, 1'b0, 1'b1}, {1'b1, 8'h01, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b0, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      step(a_tab[i], b_tab[i], op_tab[i], 1'b1);
      total++;
      if (obs() !== exp_tab[i]) begin
        bad++;
        $display("FAIL zero idx=%0d got=%h exp=%h", i, obs(), exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(8'h0A, 8'h05, 4'b0000, 1'b1);
    total++;
    if (obs() !== {1'b1, 8'h0F, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL hold_load got=%h exp=%h", obs(), {1'b1, 8'h0F, 1'b0, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      step(8'h33 + 8'(i), 8'h44, 4'b0001 + 4'(i), 1'b0);
      total++;
      if (obs() !== {1'b0, 8'h0F, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold idx=%0d got=%h exp=%h", i, obs(), {1'b0, 8'h0F, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_mid_reset();
    step(8'h0A, 8'h05, 4'b0000, 1'b1);
    A = 8'h01; B = 8'h01; ALU_Sel = 4'b0000; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs() !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs(), {1'b0, 8'h00, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1;
    total++;
    if (obs() !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_edge got=%h exp=%h", obs(), {1'b0, 8'h00, 1'b0, 1'b1});
    end
    rst = 1'b0;
    step(8'h01, 8'h01, 4'b0000, 1'b0);
    total++;
    if (obs() !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_release got=%h exp=%h", obs(), {1'b0, 8'h00, 1'b0, 1'b1});
    end
    step(8'h01, 8'h01, 4'b0000, 1'b1);
    total++;
    if (obs() !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_fresh got=%h exp=%h", obs(), {1'b1, 8'h02, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a_tab [6]   = '{8'h10, 8'h20, 8'hFF, 8'h81, 8'h07, 8'h55};
    logic [7:0]  b_tab [6]   = '{8'h20, 8'h30, 8'h0F, 8'h00, 8'h07, 8'hAA};
    logic [3:0]  op_tab [6]  = '{4'b0000, 4'b0001, 4'b0100, 4'b0110, 4'b1000, 4'b1100};
    logic [10:0] exp_tab [6] = '{
      {1'b1, 8'h30, 1'b0, 1'b0}, {1'b1, 8'hF0, 1'b1, 1'b0}, {1'b1, 8'hF0, 1'b0, 1'b0},
      {1'b1, 8'h02, 1'b1, 1'b0}, {1'b1, 8'h01, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b0, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      step(a_tab[i], b_tab[i], op_tab[i], 1'b1);
      total++;
      if (obs() !== exp_tab[i]) begin
        bad++;
        $display("FAIL b2b idx=%0d got=%h exp=%h", i, obs(), exp_tab[i]);
      end
    end
    step(8'h00, 8'h00, 4'b0000, 1'b0);
    total++;
    if (obs() !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_drain got=%h exp=%h", obs(), {1'b0, 8'h00, 1'b0, 1'b1});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sweep();
    test_carry();
    test_zero();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
